zet_wb_arbiter: RTL and testbench

Two-master Wishbone arbiter in front of the CPU switch's master port. It lets the Zet CPU (master 0) and a DMA/bus-master engine (master 1) share one 16-bit, [20:1]-address Wishbone path into the slave decoder. Grants are held for a whole cycle (cyc-locked). A per-transfer watchdog returns a dummy acknowledge when no slave responds, because the downstream switch has no default ack. Interrupt tags (tgc) pass through to master 0 only.

---
 rtl/zet_wb_pkg.sv | 18 +
 rtl/zet_wb_watchdog.sv | 47 ++++
 rtl/zet_wb_arbiter.sv | 161 ++++++++++++++++
 tb/tb_zet_wb_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zet_wb_pkg.sv
// Shared definitions for the Zet two-master Wishbone arbiter.
// Holds bus widths, the arbiter state encoding and the float value that is
// returned when no slave drives the read data.
package zet_wb_pkg;

  localparam int ADR_W  = 20;  // word address [20:1]
  localparam int DATA_W = 16;
  localparam int TGC_W  = 2;   // {nmi, intr} / {nmia, inta}

  localparam logic [DATA_W-1:0] WB_FLOAT_DATA = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

endpackage

// File: rtl/zet_wb_watchdog.sv
// Per-transfer stall watchdog for the Wishbone arbiter.
// Counts cycles in which the current owner strobes without an acknowledge and
// raises fire_o on the TIMEOUT-th such cycle so the arbiter can fake an ack.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   busy_i        : owner has cyc & stb asserted
//   ack_i         : real slave acknowledge
//   clr_i         : grant is changing on the next edge
//   fire_o        : dummy acknowledge request (combinational)
module zet_wb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic busy_i,
  input  logic ack_i,
  input  logic clr_i,
  output logic fire_o
);

  // A zero TIMEOUT still needs a legal one-bit counter; it is simply never compared.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  // A real ack in the same cycle wins over the dummy one.
  assign fire_o = (TIMEOUT != 0) && busy_i && !ack_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || ack_i || fire_o) begin
      cnt_d = '0;
    end else if (busy_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/zet_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the CPU switch master port.
// Master 0 is the Zet CPU, master 1 a DMA/bus-master engine. Grants are held
// for a whole cyc; a watchdog supplies a dummy ack when no slave answers.
// Ports:
//   wb_clk_i, wb_rst_ni      : clock, asynchronous active-low reset
//   m0_*_i / m1_*_i          : master requests (adr, sel, dat, we, cyc, stb)
//   m0_*_o / m1_*_o          : read data and acknowledge back to the masters
//   m0_tgc_i / m0_tgc_o      : inta/nmia from CPU, intr/nmi to CPU
//   s_*_o / s_*_i            : muxed bus towards the switch and its response
//   gnt_o                    : one-hot current owner
//   timeout_o                : one-cycle pulse on a watchdog acknowledge
module zet_wb_arbiter
  import zet_wb_pkg::*;
#(
  parameter int                TIMEOUT      = 64,
  parameter int                FIXED_PRIO   = 0,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = WB_FLOAT_DATA
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,

  input  logic [ADR_W-1:0]  m0_adr_i,
  input  logic [1:0]        m0_sel_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  input  logic              m0_we_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  output logic [DATA_W-1:0] m0_dat_o,
  output logic              m0_ack_o,
  input  logic [TGC_W-1:0]  m0_tgc_i,
  output logic [TGC_W-1:0]  m0_tgc_o,

  input  logic [ADR_W-1:0]  m1_adr_i,
  input  logic [1:0]        m1_sel_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  input  logic              m1_we_i,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              m1_ack_o,

  output logic [ADR_W-1:0]  s_adr_o,
  output logic [1:0]        s_sel_o,
  output logic [DATA_W-1:0] s_dat_o,
  output logic              s_we_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  input  logic [DATA_W-1:0] s_dat_i,
  input  logic              s_ack_i,
  output logic [TGC_W-1:0]  s_tgc_o,
  input  logic [TGC_W-1:0]  s_tgc_i,

  output logic [1:0]        gnt_o,
  output logic              timeout_o
);

  state_t state_q, state_d;
  logic   last_q, last_d;   // last master to release the bus
  logic   own0, own1;
  logic   own_cyc, own_stb;
  logic   wd_fire;
  logic [DATA_W-1:0] rd_dat;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          // Round-robin favours whichever master did not release last.
          state_d = ((FIXED_PRIO != 0) || last_q) ? OWN0 : OWN1;
        end else if (m0_cyc_i) begin
          state_d = OWN0;
        end else if (m1_cyc_i) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = m1_cyc_i ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = m0_cyc_i ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign own0    = (state_q == OWN0);
  assign own1    = (state_q == OWN1);
  assign own_cyc = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
  assign own_stb = (own0 & m0_stb_i) | (own1 & m1_stb_i);

  zet_wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_ni),
    .busy_i  (own_cyc & own_stb),
    .ack_i   (s_ack_i),
    .clr_i   (state_d != state_q),
    .fire_o  (wd_fire)
  );

  assign rd_dat = wd_fire ? TIMEOUT_DATA : s_dat_i;

  always_comb begin
    s_adr_o  = '0;
    s_sel_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_tgc_o  = '0;
    m0_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_dat_o = '0;
    if (own0) begin
      s_adr_o  = m0_adr_i;
      s_sel_o  = m0_sel_i;
      s_dat_o  = m0_dat_i;
      s_we_o   = m0_we_i;
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = m0_cyc_i & m0_stb_i & ~wd_fire;
      s_tgc_o  = m0_tgc_i;
      m0_ack_o = s_ack_i | wd_fire;
      m0_dat_o = rd_dat;
    end else if (own1) begin
      s_adr_o  = m1_adr_i;
      s_sel_o  = m1_sel_i;
      s_dat_o  = m1_dat_i;
      s_we_o   = m1_we_i;
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = m1_cyc_i & m1_stb_i & ~wd_fire;
      m1_ack_o = s_ack_i | wd_fire;
      m1_dat_o = rd_dat;
    end
  end

  // Interrupt requests always reach the CPU, even during reset.
  assign m0_tgc_o  = s_tgc_i;
  assign gnt_o     = {own1, own0};
  assign timeout_o = wd_fire;

endmodule

// File: tb/tb_zet_wb_arbiter.sv
module tb_zet_wb_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] m0_adr, m1_adr;
  logic [1:0]  m0_sel, m1_sel, m0_tgc, s_tgc_i;
  logic [15:0] m0_dat, m1_dat, s_dat_i;
  logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb, s_ack_i;

  logic [15:0] a_m0_dat, a_m1_dat, a_s_dat, b_m0_dat, b_m1_dat, b_s_dat;
  logic        a_m0_ack, a_m1_ack, a_s_we, a_s_cyc, a_s_stb, a_tmo;
  logic        b_m0_ack, b_m1_ack, b_s_we, b_s_cyc, b_s_stb, b_tmo;
  logic [1:0]  a_m0_tgc, a_s_sel, a_s_tgc, a_gnt, b_m0_tgc, b_s_sel, b_s_tgc, b_gnt;
  logic [19:0] a_s_adr, b_s_adr;

  int total = 0;
  int bad = 0;

  zet_wb_arbiter #(.TIMEOUT(TO), .FIXED_PRIO(0)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_adr_i(m0_adr), .m0_sel_i(m0_sel), .m0_dat_i(m0_dat), .m0_we_i(m0_we),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(a_m0_dat), .m0_ack_o(a_m0_ack),
    .m0_tgc_i(m0_tgc), .m0_tgc_o(a_m0_tgc),
    .m1_adr_i(m1_adr), .m1_sel_i(m1_sel), .m1_dat_i(m1_dat), .m1_we_i(m1_we),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(a_m1_dat), .m1_ack_o(a_m1_ack),
    .s_adr_o(a_s_adr), .s_sel_o(a_s_sel), .s_dat_o(a_s_dat), .s_we_o(a_s_we),
    .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_tgc_o(a_s_tgc), .s_tgc_i(s_tgc_i), .gnt_o(a_gnt), .timeout_o(a_tmo)
  );

  zet_wb_arbiter #(.TIMEOUT(TO), .FIXED_PRIO(1)) dut_fp (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_adr_i(m0_adr), .m0_sel_i(m0_sel), .m0_dat_i(m0_dat), .m0_we_i(m0_we),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(b_m0_dat), .m0_ack_o(b_m0_ack),
    .m0_tgc_i(m0_tgc), .m0_tgc_o(b_m0_tgc),
    .m1_adr_i(m1_adr), .m1_sel_i(m1_sel), .m1_dat_i(m1_dat), .m1_we_i(m1_we),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(b_m1_dat), .m1_ack_o(b_m1_ack),
    .s_adr_o(b_s_adr), .s_sel_o(b_s_sel), .s_dat_o(b_s_dat), .s_we_o(b_s_we),
    .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_tgc_o(b_s_tgc), .s_tgc_i(s_tgc_i), .gnt_o(b_gnt), .timeout_o(b_tmo)
  );

  task automatic drive_idle();
    m0_adr = '0; m0_sel = '0; m0_dat = '0; m0_we = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    m1_adr = '0; m1_sel = '0; m1_dat = '0; m1_we = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    m0_tgc = '0; s_tgc_i = '0; s_dat_i = '0; s_ack_i = 1'b0;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1; s_ack_i = 1'b1;
    s_tgc_i = 2'b11;
    @(posedge clk); #1;
    total++;
    if ({a_gnt, a_s_cyc, a_s_stb, a_m0_ack, a_m1_ack, a_tmo, b_gnt} !== 9'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b required=0", {a_gnt, a_s_cyc, a_s_stb, a_m0_ack, a_m1_ack, a_tmo, b_gnt});
    end
    total++;
    if (a_m0_tgc !== 2'b11) begin bad++; $display("FAIL reset_tgc11 got=%b required=11", a_m0_tgc); end
    s_tgc_i = 2'b01; #1;
    total++;
    if (a_m0_tgc !== 2'b01) begin bad++; $display("FAIL reset_tgc01 got=%b required=01", a_m0_tgc); end
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_read();
    apply_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 20'h7FFF0; m0_sel = 2'b11;
    #1;
    total++;
    if ({a_gnt, a_s_cyc} !== 3'b000) begin bad++; $display("FAIL read_latency got=%b required=000", {a_gnt, a_s_cyc}); end
    @(negedge clk);
    s_ack_i = 1'b1; s_dat_i = 16'h1234;
    #1;
    total++;
    if ({a_gnt, a_s_cyc, a_s_stb, a_s_we, a_s_adr} !== {2'b01, 1'b1, 1'b1, 1'b0, 20'h7FFF0}) begin
      bad++; $display("FAIL read_bus got=%b/%h required=01110/7fff0", {a_gnt, a_s_cyc, a_s_stb, a_s_we}, a_s_adr);
    end
    total++;
    if ({a_m0_ack, a_m1_ack, a_m0_dat, a_m1_dat} !== {1'b1, 1'b0, 16'h1234, 16'h0000}) begin
      bad++; $display("FAIL read_resp got=%b%b/%h/%h required=10/1234/0000", a_m0_ack, a_m1_ack, a_m0_dat, a_m1_dat);
    end
    @(negedge clk);
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_rr_handover();
    apply_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    @(negedge clk); #1;
    total++;
    if (a_gnt !== 2'b01) begin bad++; $display("FAIL rr_first got=%b required=01", a_gnt); end
    m0_cyc = 1'b0; #1;
    total++;
    if ({a_gnt, a_s_cyc} !== 3'b010) begin bad++; $display("FAIL rr_release got=%b required=010", {a_gnt, a_s_cyc}); end
    @(negedge clk); #1;
    total++;
    if ({a_gnt, a_s_cyc} !== 3'b101) begin bad++; $display("FAIL rr_handover got=%b required=101", {a_gnt, a_s_cyc}); end
    m1_cyc = 1'b0;
    @(negedge clk); #1;
    total++;
    if (a_gnt !== 2'b00) begin bad++; $display("FAIL rr_idle got=%b required=00", a_gnt); end
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    @(negedge clk); #1;
    total++;
    if (a_gnt !== 2'b01) begin bad++; $display("FAIL rr_second got=%b required=01", a_gnt); end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_fixed_prio();
    logic [1:0] exp_a;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      @(negedge clk); #1;
      exp_a = (i % 2 == 0) ? 2'b01 : 2'b10;
      total++;
      if (b_gnt !== 2'b01) begin bad++; $display("FAIL fixed_prio_%0d got=%b required=01", i, b_gnt); end
      total++;
      if (a_gnt !== exp_a) begin bad++; $display("FAIL rr_alt_%0d got=%b required=%b", i, a_gnt, exp_a); end
      m0_cyc = 1'b0; m1_cyc = 1'b0;
      @(negedge clk);
    end
    drive_idle();
  endtask

  task automatic test_watchdog();
    int pulses;
    apply_reset();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 20'hABCDE; m1_dat = 16'h5555; m1_sel = 2'b11;
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      if (a_tmo === 1'b1) pulses++;
      total++;
      if (k == TO) begin
        if ({a_m1_ack, a_tmo, a_s_stb, a_m0_ack} !== 4'b1100) begin
          bad++; $display("FAIL wd_fire got=%b required=1100", {a_m1_ack, a_tmo, a_s_stb, a_m0_ack});
        end
      end else if ({a_m1_ack, a_tmo, a_s_stb} !== 3'b001) begin
        bad++; $display("FAIL wd_stall_%0d got=%b required=001", k, {a_m1_ack, a_tmo, a_s_stb});
      end
      if (k == 1) begin
        total++;
        if ({a_s_we, a_s_adr, a_s_dat} !== {1'b1, 20'hABCDE, 16'h5555}) begin
          bad++; $display("FAIL wd_write_bus got=%b/%h/%h required=1/abcde/5555", a_s_we, a_s_adr, a_s_dat);
        end
      end
    end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL wd_pulse_count got=%0d required=1", pulses); end
    m1_cyc = 1'b0;
    @(negedge clk);
    m1_cyc = 1'b1; m1_we = 1'b0; s_dat_i = 16'h0BAD;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk); #1;
      total++;
      if (k == TO) begin
        if ({a_m1_ack, a_m1_dat, a_tmo} !== {1'b1, 16'hFFFF, 1'b1}) begin
          bad++; $display("FAIL wd_read got=%b/%h/%b required=1/ffff/1", a_m1_ack, a_m1_dat, a_tmo);
        end
      end else if (a_m1_ack !== 1'b0) begin
        bad++; $display("FAIL wd_read_early_%0d got=%b required=0", k, a_m1_ack);
      end
    end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_ack_race();
    apply_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 20'h00100;
    for (int k = 1; k <= 2 * TO; k++) begin
      @(negedge clk);
      s_ack_i = (k == TO);
      s_dat_i = (k == TO) ? 16'hABCD : 16'h0000;
      #1;
      total++;
      if (k == TO) begin
        if ({a_m0_ack, a_m0_dat, a_tmo, a_s_stb} !== {1'b1, 16'hABCD, 1'b0, 1'b1}) begin
          bad++; $display("FAIL race_real_ack got=%b/%h/%b/%b required=1/abcd/0/1", a_m0_ack, a_m0_dat, a_tmo, a_s_stb);
        end
      end else if (k == 2 * TO) begin
        if ({a_m0_ack, a_m0_dat, a_tmo} !== {1'b1, 16'hFFFF, 1'b1}) begin
          bad++; $display("FAIL race_refire got=%b/%h/%b required=1/ffff/1", a_m0_ack, a_m0_dat, a_tmo);
        end
      end else if ({a_m0_ack, a_tmo} !== 2'b00) begin
        bad++; $display("FAIL race_stall_%0d got=%b required=00", k, {a_m0_ack, a_tmo});
      end
    end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_tgc_reset();
    apply_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_tgc = 2'b01; s_tgc_i = 2'b10;
    @(negedge clk); #1;
    total++;
    if ({a_gnt, a_s_tgc, a_m0_tgc} !== 6'b01_01_10) begin
      bad++; $display("FAIL tgc_own0 got=%b required=010110", {a_gnt, a_s_tgc, a_m0_tgc});
    end
    m0_cyc = 1'b0; m1_cyc = 1'b1; m1_stb = 1'b1;
    @(negedge clk); #1;
    total++;
    if ({a_gnt, a_s_tgc, a_m0_tgc} !== 6'b10_00_10) begin
      bad++; $display("FAIL tgc_own1 got=%b required=100010", {a_gnt, a_s_tgc, a_m0_tgc});
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({a_s_cyc, a_s_stb, a_gnt, a_m0_tgc} !== 6'b00_00_10) begin
      bad++; $display("FAIL async_reset got=%b required=000010", {a_s_cyc, a_s_stb, a_gnt, a_m0_tgc});
    end
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int own [2];
    int lst [2];
    int cnt [2];
    int no;
    bit busy, fire, ack, cyc_o, stb_o;
    logic [42:0] eb, ob;
    logic [38:0] er, orr;
    logic [15:0] rdat;
    apply_reset();
    for (int d = 0; d < 2; d++) begin own[d] = -1; lst[d] = 1; cnt[d] = 0; end
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(0, 9) == 0) m1_cyc = ~m1_cyc;
      m0_stb = ($urandom_range(0, 3) != 0); m1_stb = ($urandom_range(0, 3) != 0);
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_adr = 20'($urandom); m1_adr = 20'($urandom);
      m0_sel = 2'($urandom); m1_sel = 2'($urandom);
      m0_dat = 16'($urandom); m1_dat = 16'($urandom);
      m0_tgc = 2'($urandom); s_tgc_i = 2'($urandom);
      s_ack_i = ($urandom_range(0, 11) == 0); s_dat_i = 16'($urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        cyc_o = (own[d] == 0) ? m0_cyc : (own[d] == 1) ? m1_cyc : 1'b0;
        stb_o = (own[d] == 0) ? m0_stb : (own[d] == 1) ? m1_stb : 1'b0;
        busy = cyc_o && stb_o;
        fire = busy && !s_ack_i && (cnt[d] == TO - 1);
        ack  = (own[d] >= 0) && (s_ack_i || fire);
        rdat = fire ? 16'hFFFF : s_dat_i;
        if (own[d] == 0) begin
          eb = {2'b01, cyc_o, busy && !fire, m0_we, m0_sel, m0_adr, m0_dat};
          er = {ack, 1'b0, rdat, 16'h0000, fire, m0_tgc, s_tgc_i};
        end else if (own[d] == 1) begin
          eb = {2'b10, cyc_o, busy && !fire, m1_we, m1_sel, m1_adr, m1_dat};
          er = {1'b0, ack, 16'h0000, rdat, fire, 2'b00, s_tgc_i};
        end else begin
          eb = '0;
          er = {37'b0, s_tgc_i};
        end
        ob  = (d == 0) ? {a_gnt, a_s_cyc, a_s_stb, a_s_we, a_s_sel, a_s_adr, a_s_dat}
                       : {b_gnt, b_s_cyc, b_s_stb, b_s_we, b_s_sel, b_s_adr, b_s_dat};
        orr = (d == 0) ? {a_m0_ack, a_m1_ack, a_m0_dat, a_m1_dat, a_tmo, a_s_tgc, a_m0_tgc}
                       : {b_m0_ack, b_m1_ack, b_m0_dat, b_m1_dat, b_tmo, b_s_tgc, b_m0_tgc};
        total++;
        if (ob !== eb) begin bad++; $display("FAIL rand_bus dut%0d cyc%0d got=%h required=%h", d, c, ob, eb); end
        total++;
        if (orr !== er) begin bad++; $display("FAIL rand_resp dut%0d cyc%0d got=%h required=%h", d, c, orr, er); end
        // Next owner from the arbitration rules.
        no = own[d];
        if (own[d] < 0) begin
          if (m0_cyc && m1_cyc) no = (d == 1 || lst[d] == 1) ? 0 : 1;
          else if (m0_cyc) no = 0;
          else if (m1_cyc) no = 1;
        end else if (!cyc_o) begin
          lst[d] = own[d];
          if (own[d] == 0) no = m1_cyc ? 1 : -1;
          else no = m0_cyc ? 0 : -1;
        end
        if (no != own[d]) cnt[d] = 0;
        else if (s_ack_i || fire) cnt[d] = 0;
        else if (busy) cnt[d] = cnt[d] + 1;
        own[d] = no;
      end
    end
    drive_idle();
    @(negedge clk);
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_basic_read();
    test_rr_handover();
    test_fixed_prio();
    test_watchdog();
    test_ack_race();
    test_tgc_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
